// File: rtl/nios_system_sw_hw_handshake_if.sv
// Avalon-MM slave bus plus engine req/ack handshake signals for nios_system_sw_hw_handshake.
// The slave modport is the handshake block; master is the CPU/engine side.
interface nios_system_sw_hw_handshake_if #(
    parameter int CMD_W = 8,
    parameter int RES_W = 16
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [CMD_W-1:0] cmd_out;
    logic             hw_req;
    logic             hw_ack;
    logic [RES_W-1:0] hw_result;
    logic             irq;

    modport slave (
        input  address, chipselect, write_n, writedata, hw_ack, hw_result,
        output readdata, cmd_out, hw_req, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, hw_ack, hw_result,
        input  readdata, cmd_out, hw_req, irq
    );
endinterface

// File: rtl/nios_system_sw_hw_handshake.sv
// Software-to-engine four-phase req/ack sequencer with timeout and sticky status.
// Define NIOS_SYSTEM_SW_HW_IRQ_EN to build the IRQ_MASK register and a registered irq.
module nios_system_sw_hw_handshake #(
    parameter int CMD_W = 8,
    parameter int RES_W = 16,
    parameter int TO_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_system_sw_hw_handshake_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_hw_req;
    logic [CMD_W-1:0] r_cmd;
    logic [RES_W-1:0] r_result;
    logic [TO_W-1:0]  r_limit, r_cnt;
    logic             r_done, r_to, r_err;

    logic        w_wr, w_start, w_abort, w_busy, w_expire;
    logic        w_capture, w_set_done, w_set_to, w_set_err, w_clr_st;
    logic [2:0]  w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr     = bus.chipselect & ~bus.write_n;
    // ABORT in the same write masks START, so a combined write never launches or flags err.
    assign w_abort  = w_wr && (bus.address == 3'd1) && bus.writedata[1];
    assign w_start  = w_wr && (bus.address == 3'd1) && bus.writedata[0] && !bus.writedata[1];
    assign w_busy   = (r_state != S_IDLE);
    assign w_expire = (r_limit != '0) && (r_cnt == r_limit - TO_W'(1));
    assign w_set_err = w_busy & w_start;
    assign w_w1c    = (w_wr && (bus.address == 3'd2)) ? bus.writedata[3:1] : 3'b000;
    assign w_unused = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Priority while busy: abort, then timeout, then the handshake edge.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_set_done  = 1'b0;
        w_set_to    = 1'b0;
        w_clr_st    = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) begin
                w_state_nxt = S_REQ;
                w_clr_st    = 1'b1;
            end
            S_REQ: begin
                if (w_abort) w_state_nxt = S_IDLE;
                else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_set_to    = 1'b1;
                end else if (bus.hw_ack) begin
                    w_state_nxt = S_DROP;
                    w_capture   = 1'b1;
                end
            end
            S_DROP: begin
                if (w_abort) w_state_nxt = S_IDLE;
                else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_set_to    = 1'b1;
                end else if (!bus.hw_ack) begin
                    w_state_nxt = S_IDLE;
                    w_set_done  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hw_req <= 1'b0;
            r_cmd    <= '0;
            r_result <= '0;
            r_limit  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_hw_req <= (w_state_nxt == S_REQ);
            if (w_wr && (bus.address == 3'd0) && !w_busy) r_cmd <= bus.writedata[CMD_W-1:0];
            if (w_wr && (bus.address == 3'd4)) r_limit <= bus.writedata[TO_W-1:0];
            if (w_capture) r_result <= bus.hw_result;
            if (w_clr_st)                      r_cnt <= '0;
            else if (w_busy && (r_cnt != '1))  r_cnt <= r_cnt + TO_W'(1);
            // Hardware sets take precedence over a same-cycle software clear.
            r_done <= w_set_done | (r_done & ~w_w1c[0] & ~w_clr_st);
            r_to   <= w_set_to   | (r_to   & ~w_w1c[1] & ~w_clr_st);
            r_err  <= w_set_err  | (r_err  & ~w_w1c[2]);
        end
    end

`ifdef NIOS_SYSTEM_SW_HW_IRQ_EN
    logic [2:0] r_mask;
    logic       r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= 3'b000;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (bus.address == 3'd5)) r_mask <= bus.writedata[2:0];
            r_irq <= |({r_err, r_to, r_done} & r_mask);
        end
    end
    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            3'd0: w_rdata = 32'(r_cmd);
            3'd2: w_rdata = {28'd0, r_err, r_to, r_done, w_busy};
            3'd3: w_rdata = 32'(r_result);
            3'd4: w_rdata = 32'(r_limit);
`ifdef NIOS_SYSTEM_SW_HW_IRQ_EN
            3'd5: w_rdata = {29'd0, r_mask};
`endif
            default: w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;
    assign bus.cmd_out  = r_cmd;
    assign bus.hw_req   = r_hw_req;
endmodule

// File: doc/nios_system_sw_hw_handshake.md
Name: nios_system_sw_hw_handshake

Overview:
Avalon-MM slave that sequences a four-phase req/ack handshake between Nios II software and one hardware engine. Software loads a command word and writes START. The block drives hw_req until the engine acks, then latches the engine's result and waits for ack to drop. It reports done, timeout or error in a status register. Sits on the system interconnect beside the PIO peripherals and replaces bare single-bit software-to-hardware flags.

Parameters:
CMD_W, 8, width of command word driven to the engine
RES_W, 16, width of result word captured from the engine
TO_W, 16, width of timeout limit/counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero-extended
cmd_out  out  CMD_W  command word to engine
hw_req  out  1  request to engine
hw_ack  in  1  acknowledge from engine, synchronous to clk
hw_result  in  RES_W  engine result, valid while hw_ack=1
irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Write = chipselect & ~write_n. Reads are combinational, zero wait-state; readdata is a pure function of address and current register state.
- Register map (word addresses):
  - 0 CMD, RW: bits[CMD_W-1:0] drive cmd_out. Writes are ignored while busy.
  - 1 CTRL, WO, reads 0: bit0 START, bit1 ABORT.
  - 2 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 timeout (W1C), bit3 err (W1C).
  - 3 RESULT, RO: last captured hw_result.
  - 4 TIMEOUT, RW: limit[TO_W-1:0]; 0 disables the timeout.
  - 5 IRQ_MASK, RW: bits[2:0] gate done/timeout/err.
  - 6-7: reserved, read 0, writes ignored.
- FSM states: IDLE, REQ, DROP.
  - IDLE: hw_req=0. START moves to REQ the next cycle, sets hw_req=1 registered, clears done/timeout, and zeroes the counter.
  - REQ: hw_req=1. When hw_ack=1, capture RESULT<=hw_result on that edge, drop hw_req, and go to DROP.
  - DROP: hw_req=0. When hw_ack=0, go to IDLE and set done=1.
  - busy = (state != IDLE).
- Timeout counter: increments each cycle in REQ or DROP. If limit != 0 and counter == limit-1, go to IDLE, drop hw_req, set timeout=1, and leave RESULT unchanged. The counter saturates and does not wrap.
- ABORT while busy: go to IDLE next cycle, hw_req=0, neither done nor timeout set. ABORT in IDLE has no effect.
- START while busy: ignored, err=1.
- START and ABORT in the same write: ABORT wins; a START in IDLE with ABORT set is ignored.
- W1C to STATUS on the same cycle the FSM sets that bit: the set wins.
- Reset values: state=IDLE, hw_req=0, cmd_out=0, RESULT=0, TIMEOUT=0, IRQ_MASK=0, all status bits 0, irq=0, counter 0.
- Reset mid-handshake: hw_req drops asynchronously. The engine must tolerate an abandoned request.

Optional Feature:
NIOS_SYSTEM_SW_HW_IRQ_EN.
- Defined: irq is registered, irq = |(STATUS[3:1] & IRQ_MASK[2:0]). It asserts the cycle after the triggering status bit sets and deasserts the cycle after the W1C.
- Undefined: irq is tied 0, IRQ_MASK is not implemented and reads 0, and writes to address 5 are ignored.

Test Plan:
- Reset, then read addresses 0-7: all return 0; hw_req=0.
- Write CMD=0xA5, START; engine acks 3 cycles after hw_req rises with hw_result=0x1234, drops ack 2 cycles later. Expect cmd_out=0xA5, hw_req high 1 cycle after START, RESULT=0x1234, STATUS=0x2 after ack falls.
- TIMEOUT=10, START, no ack: hw_req falls after 10 cycles; STATUS=0x4; RESULT unchanged.
- START during REQ: STATUS.err=1, handshake continues normally. Write STATUS=0x8: err clears.
- ABORT while in REQ: hw_req=0 next cycle, busy=0, STATUS.done=0. Assert reset_n=0 mid-REQ: hw_req drops immediately.
- With IRQ_EN and IRQ_MASK=0x1: completed handshake raises irq one cycle after done. W1C of done lowers irq the following cycle. Timeout alone leaves irq low.
